// File: rtl/weight_feeder.sv
// Weight-FIFO feeder: streams a tile of weight rows from BRAM into the weight FIFO.
// Optional build macro WEIGHT_FEEDER_ZERO_PAD_EN pads the tile to a multiple of MUL_SIZE rows.
module weight_feeder #(
  parameter int MUL_SIZE = 32,
  parameter int W_WIDTH  = 7,
  parameter int ADDR_W   = 12,
  parameter int ROWS_W   = 9
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [ADDR_W-1:0]                base_addr_i,
  input  logic [ROWS_W-1:0]                num_rows_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             mem_rd_en_o,
  output logic [ADDR_W-1:0]                mem_addr_o,
  input  logic [MUL_SIZE-1:0][W_WIDTH:0]   mem_rd_data_i,
  output logic                             write_en_o,
  input  logic                             request_data_i,
  output logic                             sending_data_o,
  output logic [MUL_SIZE-1:0][W_WIDTH:0]   data_o
);

  // One extra bit so a padded count of 2^ROWS_W still fits.
  localparam int CNT_W = ROWS_W + 1;

  typedef logic [MUL_SIZE-1:0][W_WIDTH:0] row_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  accepted;
  logic              inflight;
  logic [1:0]        occ;
  logic              valid;
  row_t              buf0;
  row_t              buf1;

  logic              accept;
  logic              issue;
  logic              push;
  row_t              din;
  logic [1:0]        occ_nxt;
  logic [CNT_W-1:0]  start_total;

`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
  logic [CNT_W-1:0]  real_rows;
  logic              pad_inflight;

  assign start_total = CNT_W'(
    (int'(num_rows_i) + MUL_SIZE - 1)
    / MUL_SIZE * MUL_SIZE);
  assign mem_rd_en_o = issue
    & (issued < real_rows);
  assign din = pad_inflight
    ? row_t'('0) : mem_rd_data_i;
`else
  assign start_total = CNT_W'(num_rows_i);
  assign mem_rd_en_o = issue;
  assign din = mem_rd_data_i;
`endif

  assign accept = request_data_i & valid;
  assign push   = inflight;

  // Issue only when the row will surely
  // have a buffer slot on return.
  assign issue = (state == STREAM)
    & (issued < total)
    & (({1'b0, occ} + {2'b0, inflight})
       < (3'd2 + {2'b0, accept}));

  assign mem_addr_o = base + ADDR_W'(issued);

  assign occ_nxt = occ + {1'b0, push}
                 - {1'b0, accept};

  assign busy_o         = (state == STREAM);
  assign write_en_o     = (state == STREAM);
  assign done_o         = (state == DONE);
  assign sending_data_o = valid;
  assign data_o         = buf0;

  // Tile control: latch the request, count
  // issued/accepted rows, sequence states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      base     <= '0;
      total    <= '0;
      issued   <= '0;
      accepted <= '0;
`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
      real_rows <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            base     <= base_addr_i;
            total    <= start_total;
            issued   <= '0;
            accepted <= '0;
`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
            real_rows <= CNT_W'(num_rows_i);
`endif
            state <= (start_total == '0)
              ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (issue)
            issued <= issued + 1'b1;
          if (accept) begin
            accepted <= accepted + 1'b1;
            if (accepted == total - 1'b1)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read in flight so its return
  // lands in the buffer one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
      pad_inflight <= 1'b0;
`endif
    end else begin
      inflight <= issue;
`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
      pad_inflight <= issue
        & (issued >= real_rows);
`endif
    end
  end

  // Two-entry row buffer; buf0 is the head
  // and drives data_o directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ   <= '0;
      valid <= 1'b0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      occ   <= occ_nxt;
      valid <= (occ_nxt != 2'd0);
      case ({push, accept})
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= din;
          end else begin
            buf0 <= din;
          end
        end
        2'b01: buf0 <= buf1;
        2'b10: begin
          if (occ == 2'd0) buf0 <= din;
          else             buf1 <= din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_feeder.sv
// Self-checking bench for weight_feeder against a
// row-queue reference model.
module tb_weight_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [11:0]  base;
  logic [8:0]   num;
  logic         busy, done, rd_en, wr_en;
  logic [11:0]  addr;
  logic [255:0] rdata;
  logic         request;
  logic         sending;
  logic [255:0] data;

  logic [255:0] mem [4096];

  int n_chk = 0;
  int n_pass = 0;

  weight_feeder dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_addr_i(base), .num_rows_i(num),
    .busy_o(busy), .done_o(done),
    .mem_rd_en_o(rd_en), .mem_addr_o(addr),
    .mem_rd_data_i(rdata), .write_en_o(wr_en),
    .request_data_i(request),
    .sending_data_o(sending), .data_o(data)
  );

  always #5 clk = ~clk;

  // Synchronous weight BRAM, one-cycle read.
  always @(posedge clk)
    if (rd_en) rdata <= mem[addr];

  // Observation state (monitor is sole writer).
  logic [255:0] got_q [$];
  logic [11:0]  rd_q [$];
  int done_cnt, flag_bad, stall_bad, occ_bad;
  int cyc = 0;
  int start_cyc, first_rd, last_rd;
  int first_snd, last_acc, done_cyc;
  int occ_m;
  bit r1, r2, a1, pstall;
  logic [255:0] pdata;
  bit mon_clr = 1'b0;

  // Expected model.
  logic [255:0] exp_q [$];
  logic [11:0]  expa_q [$];

  always @(negedge clk) begin
    cyc++;
    if (mon_clr || rst) begin
      got_q.delete(); rd_q.delete();
      done_cnt = 0; flag_bad = 0;
      stall_bad = 0; occ_bad = 0;
      start_cyc = -1; first_rd = -1;
      last_rd = -1; first_snd = -1;
      last_acc = -1; done_cyc = -1;
      occ_m = 0; r1 = 0; r2 = 0; a1 = 0;
      pstall = 0; pdata = '0;
    end else begin
      if (start && start_cyc < 0)
        start_cyc = cyc;
      if (rd_en) begin
        rd_q.push_back(addr);
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (sending && first_snd < 0)
        first_snd = cyc;
      if (request && sending) begin
        got_q.push_back(data);
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done && busy) flag_bad++;
      if (sending && !busy) flag_bad++;
      if (wr_en !== busy) flag_bad++;
      if (pstall && !(sending === 1'b1
          && data === pdata))
        stall_bad++;
      pstall = sending && !request;
      pdata = data;
      // Rows in buffer = reads returned
      // minus rows accepted so far.
      occ_m = occ_m + int'(r2) - int'(a1);
`ifndef WEIGHT_FEEDER_ZERO_PAD_EN
      if (sending !== (occ_m != 0))
        occ_bad++;
      if (occ_m > 2) occ_bad++;
      if (rd_en && (occ_m + int'(r1)
          - int'(request && sending) >= 2))
        occ_bad++;
`endif
      r2 = r1;
      r1 = rd_en;
      a1 = request && sending;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic build_exp(
    input logic [11:0] b, input int n);
    int tot;
    logic [11:0] a;
`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
    tot = (n + 31) / 32 * 32;
`else
    tot = n;
`endif
    exp_q.delete(); expa_q.delete();
    for (int i = 0; i < tot; i++) begin
      a = b + 12'(i);
      if (i < n) begin
        exp_q.push_back(mem[a]);
        expa_q.push_back(a);
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  function automatic logic pat(
    input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_tile(
    input logic [11:0] b, input int n,
    input int mode, input int inj,
    output bit to);
    clear_mon();
    build_exp(b, n);
    @(posedge clk); #1;
    start = 1'b1; base = b; num = 9'(n);
    request = pat(mode, 0);
    to = 1'b1;
    for (int c = 1; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
      request = pat(mode, c);
      if (c == inj) begin
        start = 1'b1;
        base = b + 12'h100;
        num = 9'(n + 3);
      end else begin
        start = 1'b0;
        base = 12'($urandom);
        num = 9'($urandom);
      end
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 request = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    base = '0; num = '0; request = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, rd_en, wr_en, sending}
        !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000",
        {busy, done, rd_en, wr_en, sending});
    else n_pass++;
    n_chk++;
    if (addr !== 12'h0)
      $display("FAIL reset_addr got %h want 000",
        addr);
    else n_pass++;
    n_chk++;
    if (data !== '0)
      $display("FAIL reset_data got %h want 0",
        data);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    run_tile(12'h010, 4, 0, -1, to);
    n_chk++;
    if (to) $display("FAIL basic_timeout got no done want done");
    else n_pass++;
    n_chk++;
    if (got_q.size() != exp_q.size())
      $display("FAIL basic_count got %0d want %0d",
        got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size()
         && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL basic_row%0d got %h want %h",
          i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_chk++;
    if (rd_q != expa_q)
      $display("FAIL basic_addrs got %p want %p",
        rd_q, expa_q);
    else n_pass++;
    n_chk++;
    if (last_rd - first_rd != 3)
      $display("FAIL basic_rd_span got %0d want 3",
        last_rd - first_rd);
    else n_pass++;
    n_chk++;
    if (first_rd - start_cyc != 1)
      $display("FAIL lat_first_rd got %0d want 1",
        first_rd - start_cyc);
    else n_pass++;
    n_chk++;
    if (first_snd - start_cyc != 3)
      $display("FAIL lat_first_snd got %0d want 3",
        first_snd - start_cyc);
    else n_pass++;
    n_chk++;
    if (done_cyc - last_acc != 1)
      $display("FAIL lat_done got %0d want 1",
        done_cyc - last_acc);
    else n_pass++;
    n_chk++;
    if (done_cnt != 1 || flag_bad != 0)
      $display("FAIL basic_flags got done=%0d bad=%0d want 1 0",
        done_cnt, flag_bad);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit to;
    run_tile(12'h123, 6, 1, -1, to);
    n_chk++;
    if (to || got_q != exp_q)
      $display("FAIL stall_rows got n=%0d to=%0d want n=%0d",
        got_q.size(), to, exp_q.size());
    else n_pass++;
    n_chk++;
    if (stall_bad != 0)
      $display("FAIL stall_hold got %0d want 0",
        stall_bad);
    else n_pass++;
    n_chk++;
    if (occ_bad != 0)
      $display("FAIL stall_occ got %0d want 0",
        occ_bad);
    else n_pass++;
    n_chk++;
    if (done_cnt != 1 || rd_q != expa_q)
      $display("FAIL stall_done got done=%0d rd=%0d want 1 %0d",
        done_cnt, rd_q.size(), expa_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    logic [11:0] b;
    int n;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 12'hFFC
        : 12'($urandom);
      n = $urandom_range(1, 40);
      run_tile(b, n, 2, -1, to);
      n_chk++;
      if (to || got_q != exp_q
          || rd_q != expa_q)
        $display("FAIL rand%0d got n=%0d rd=%0d to=%0d want n=%0d rd=%0d",
          k, got_q.size(), rd_q.size(), to,
          exp_q.size(), expa_q.size());
      else n_pass++;
      n_chk++;
      if (stall_bad + occ_bad + flag_bad != 0
          || done_cnt != 1)
        $display("FAIL rand%0d_prot got %0d/%0d/%0d d=%0d want 0/0/0 d=1",
          k, stall_bad, occ_bad, flag_bad,
          done_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    bit to;
    run_tile(12'h055, 0, 0, -1, to);
    n_chk++;
    if (rd_q.size() != 0 || got_q.size() != 0)
      $display("FAIL zero_traffic got rd=%0d rows=%0d want 0 0",
        rd_q.size(), got_q.size());
    else n_pass++;
    n_chk++;
    if (to || done_cyc - start_cyc != 1)
      $display("FAIL zero_done got %0d want 1",
        done_cyc - start_cyc);
    else n_pass++;
    n_chk++;
    if (first_snd != -1 || done_cnt != 1)
      $display("FAIL zero_snd got snd=%0d d=%0d want -1 1",
        first_snd, done_cnt);
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    bit to;
    run_tile(12'h200, 10, 0, 4, to);
    n_chk++;
    if (to || got_q != exp_q)
      $display("FAIL restart_rows got n=%0d want n=%0d",
        got_q.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (rd_q != expa_q || done_cnt != 1)
      $display("FAIL restart_rd got rd=%0d d=%0d want %0d 1",
        rd_q.size(), done_cnt, expa_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    bit hit;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base = 12'h300;
    num = 9'd8; request = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (got_q.size() >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) $display("FAIL mid_reach got <2 accepts want 2");
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, rd_en, wr_en, sending}
        !== 5'b0 || addr !== 12'h0
        || data !== '0)
      $display("FAIL mid_async got %b %h want 00000 000",
        {busy, done, rd_en, wr_en, sending},
        addr);
    else n_pass++;
    request = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    run_tile(12'h7F0, 8, 2, -1, to);
    n_chk++;
    if (to || got_q != exp_q
        || rd_q != expa_q || done_cnt != 1)
      $display("FAIL mid_restart got n=%0d rd=%0d d=%0d want %0d %0d 1",
        got_q.size(), rd_q.size(), done_cnt,
        exp_q.size(), expa_q.size());
    else n_pass++;
  endtask

  task automatic test_pad();
    bit to;
    int zeros;
    run_tile(12'h400, 33, 0, -1, to);
    n_chk++;
    if (rd_q.size() != 33)
      $display("FAIL pad_reads got %0d want 33",
        rd_q.size());
    else n_pass++;
    zeros = 0;
    for (int i = 33; i < got_q.size(); i++)
      if (got_q[i] === '0) zeros++;
    n_chk++;
    if (to || got_q != exp_q
        || zeros != exp_q.size() - 33)
      $display("FAIL pad_rows got n=%0d z=%0d want n=%0d z=%0d",
        got_q.size(), zeros, exp_q.size(),
        exp_q.size() - 33);
    else n_pass++;
    n_chk++;
    if (done_cnt != 1 || done_cyc - last_acc != 1)
      $display("FAIL pad_done got d=%0d lag=%0d want 1 1",
        done_cnt, done_cyc - last_acc);
    else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++)
      for (int w = 0; w < 8; w++)
        mem[a][w*32 +: 32] = $urandom;
    rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_restart_ignored();
    test_random();
    test_reset_mid();
    test_pad();
    $display("%0d/%0d checks passed",
      n_pass, n_chk);
    $finish;
  end

endmodule
